// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b with borrow-out, one bit per clock, LSB first.
// Define SUB_SATURATE_EN to clamp a negative result to zero (bout still reports the borrow).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ai, bi, d_bit, br_nxt, last_bit;
  logic [WIDTH-1:0] res_full, load_val;

  // One full-subtractor cell; the result register keeps only the bits already produced.
  assign ai       = a_sh_q[0];
  assign bi       = b_sh_q[0];
  assign d_bit    = ai ^ bi ^ br_q;
  assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_full = {d_bit, res_q};

`ifdef SUB_SATURATE_EN
  assign load_val = br_nxt ? '0 : res_full;
`else
  assign load_val = res_full;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    zero_d = zero_q;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          res_d  = '0;
          br_d   = 1'b0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_full[WIDTH-1:1];
        br_d   = br_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          diff_d = load_val;
          bout_d = br_nxt;
          zero_d = (load_val == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=4 instances against an arithmetic model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bout8, zero8;
  logic       busy4, done4, bout4, zero4;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns {zero, bout, diff} from plain modular arithmetic.
  function automatic logic [9:0] model(input int unsigned a, input int unsigned b, input int unsigned w);
    int unsigned m, d;
    bit bo;
    m  = 32'd1 << w;
    d  = (a + m - b) % m;
    bo = (a < b);
`ifdef SUB_SATURATE_EN
    if (bo) d = 0;
`endif
    return {(d == 0), bo, 8'(d)};
  endfunction

  function automatic logic [7:0] obs_diff(input bit w4);
    return w4 ? {4'b0, diff4} : diff8;
  endfunction
  function automatic logic obs_busy(input bit w4);
    return w4 ? busy4 : busy8;
  endfunction
  function automatic logic obs_done(input bit w4);
    return w4 ? done4 : done8;
  endfunction
  function automatic logic obs_bout(input bit w4);
    return w4 ? bout4 : bout8;
  endfunction
  function automatic logic obs_zero(input bit w4);
    return w4 ? zero4 : zero8;
  endfunction

  task automatic drive(input bit w4, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w4) begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0];
    end else begin
      start8 = s; a8 = a; b8 = b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input bit w4, input logic [7:0] a, input logic [7:0] b);
    int unsigned w;
    logic [9:0] exp;
    logic [7:0] prev;
    int cyc, busyc;
    bit held;
    w     = w4 ? 4 : 8;
    if (w4) begin
      a[7:4] = 4'b0;
      b[7:4] = 4'b0;
    end
    exp   = model(a, b, w);
    prev  = obs_diff(w4);
    drive(w4, 1'b1, a, b);
    tick();
    drive(w4, 1'b0, 8'($urandom), 8'($urandom));
    cyc   = 0;
    busyc = 0;
    held  = 1'b1;
    while (!obs_done(w4) && cyc < int'(4 * w)) begin
      if (obs_busy(w4)) busyc++;
      if (obs_diff(w4) !== prev) held = 1'b0;
      tick();
      cyc++;
    end
    check({tag, ".latency"}, cyc, w);
    check({tag, ".busy_cycles"}, busyc, w);
    check({tag, ".held_in_run"}, 32'(held), 1);
    check({tag, ".busy_at_done"}, 32'(obs_busy(w4)), 0);
    check({tag, ".diff"}, 32'(obs_diff(w4)), 32'(exp[7:0]));
    check({tag, ".bout"}, 32'(obs_bout(w4)), 32'(exp[8]));
    check({tag, ".zero"}, 32'(obs_zero(w4)), 32'(exp[9]));
    tick();
    check({tag, ".done_one_cycle"}, 32'(obs_done(w4)), 0);
  endtask

  initial begin
    logic [9:0] exp;
    int dones;

    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    tick();
    tick();
    check("rst.busy", 32'(busy8), 0);
    check("rst.done", 32'(done8), 0);
    check("rst.diff", 32'(diff8), 0);
    check("rst.bout", 32'(bout8), 0);
    check("rst.zero", 32'(zero8), 0);
    check("rst.diff4", 32'(diff4), 0);
    rst = 1'b0;
    tick();

    do_op("w8_9m5", 1'b0, 8'd9, 8'd5);
    do_op("w8_3m7", 1'b0, 8'd3, 8'd7);
    do_op("w4_15m9", 1'b1, 8'd15, 8'd9);
    do_op("w4_3m7", 1'b1, 8'd3, 8'd7);
    do_op("w8_eq", 1'b0, 8'd170, 8'd170);
    do_op("w8_0m255", 1'b0, 8'd0, 8'd255);
    do_op("w8_255m0", 1'b0, 8'd255, 8'd0);
    do_op("w4_0m1", 1'b1, 8'd0, 8'd1);
    for (int i = 0; i < 12; i++) do_op("rand8", 1'b0, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) do_op("rand4", 1'b1, 8'($urandom_range(15)), 8'($urandom_range(15)));

    // Spurious starts during RUN and DONE must be ignored.
    exp = model(100, 30, 8);
    drive(1'b0, 1'b1, 8'd100, 8'd30);
    tick();
    drive(1'b0, 1'b0, 8'd100, 8'd30);
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3 || k == 9) drive(1'b0, 1'b1, 8'd1, 8'd0);
      else if (k == 4 || k == 10) drive(1'b0, 1'b0, 8'd1, 8'd0);
      if (done8) dones++;
      tick();
    end
    check("ign.done_count", dones, 1);
    check("ign.diff", 32'(diff8), 32'(exp[7:0]));
    check("ign.bout", 32'(bout8), 32'(exp[8]));

    // Reset during RUN aborts with no done pulse.
    drive(1'b0, 1'b1, 8'd50, 8'd10);
    tick();
    drive(1'b0, 1'b0, 8'd50, 8'd10);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy8), 0);
    check("abort.done", 32'(done8), 0);
    check("abort.diff", 32'(diff8), 0);
    check("abort.bout", 32'(bout8), 0);
    check("abort.zero", 32'(zero8), 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8 || busy8) dones++;
      tick();
    end
    check("abort.no_activity", dones, 0);
    do_op("after_rst", 1'b0, 8'd200, 8'd55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, multi-cycle, bit-serial successor to the 4-bit combinational parallel subtractor.
- Computes diff = a - b with borrow-out, processing one bit per clock, LSB first.
- Uses a start/done handshake.
- Sits in the vending datapath between the credit register and the change/display logic; trades latency for one full-subtractor cell at any WIDTH.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH): bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  minuend, sampled with start
- b  input  WIDTH  subtrahend, sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result registers just updated
- diff  output  WIDTH  registered difference
- bout  output  1  registered borrow-out; 1 when a < b unsigned
- zero  output  1  registered; 1 when diff == 0

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, diff=0, bout=0, zero=0; internal shift registers, borrow and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - on edge with start=1, latch a and b into shift registers, borrow=0, count=0, go RUN.
  - start=0 stays IDLE.
- RUN, every edge:
  - ai=a_sh[0], bi=b_sh[0].
  - d = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - d is shifted into the result shift register from the MSB side; a_sh and b_sh shift right; count++.
  - When count == WIDTH-1 on that edge: go DONE and load the output registers in the same edge:
    - diff = completed result
    - bout = br_next
    - zero = (completed result == 0)
- DONE: done=1 for exactly one cycle; next edge goes IDLE unconditionally.
- Latency: start accepted at edge E0 -> done high in the cycle following edge E_WIDTH (WIDTH cycles after acceptance).
- Minimum start-to-start spacing: WIDTH+2 cycles.
- Arithmetic: diff = (a - b) mod 2^WIDTH; bout = (a < b) unsigned.
- Output registers hold the last result until the next DONE load. They do not change during RUN.
- start during RUN or DONE is ignored; operands are not re-sampled.
- a/b changes after acceptance have no effect on the operation in flight.
- rst asserted mid-RUN: abort immediately; all outputs return to reset values; no done pulse.
- Equal operands: diff=0, bout=0, zero=1.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when the final borrow is 1, diff is loaded as 0 and zero=1; bout still reports 1.
- Undefined: diff is the wrapped modular result; zero reflects the wrapped value.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=8, a=9, b=5, start pulse -> after 8 cycles done=1 for one cycle, diff=4, bout=0, zero=0; busy high for exactly 8 cycles.
- WIDTH=8, a=3, b=7 -> diff=252, bout=1, zero=0. With SUB_SATURATE_EN: diff=0, bout=1, zero=1.
- WIDTH=4 instance, a=15, b=9 -> diff=6, bout=0. Then a=3, b=7 -> diff=12, bout=1; same done timing scaled to 4 cycles.
- WIDTH=8, a=b=170 -> diff=0, bout=0, zero=1.
- start pulsed again with a=1, b=0 at cycles 3 and WIDTH (during RUN/DONE) -> ignored; first result unchanged; exactly one done pulse.
- rst asserted at cycle 4 of RUN -> outputs 0 immediately, no done. Re-start with a=200, b=55 -> diff=145, bout=0.
